// File: rtl/sub64_pkg.sv
// Shared constants and state encoding for the sequential 64-bit subtractor.
package sub64_pkg;

    localparam int N_DEF      = 64;
    localparam int CHUNK_DEF  = 16;
    localparam int NUM_CHUNKS = N_DEF / CHUNK_DEF;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_64_seq_chunk_adder.sv
// Combinational W-bit ripple-carry adder, reused every cycle for one slice.
module chunk_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Bit-serial carry propagation across the slice
    always_comb begin
        logic c;
        c   = cin;
        sum = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/sub_64_seq.sv
// Multi-cycle subtractor: a + b_n + 1 one CHUNK slice per cycle, with Y86 flags.
// Optional macro SUB64_SEQ_ADD_MODE_EN adds an op_add input selecting a + b_n.
module sub_64_seq
    import sub64_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b_n,
`ifdef SUB64_SEQ_ADD_MODE_EN
    input  logic         op_add,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         cout
);

    localparam int NCH = N / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t         state_r, state_s;
    logic [IW-1:0]  idx_r;
    logic           carry_r;
    logic [N-1:0]   a_r, b_r;
    logic           add_r;
    logic [N-1:0]   diff_r;
    logic           zf_r, sf_r, of_r, cout_r;
    logic           out_valid_r, in_ready_r;

    logic [CHUNK-1:0] a_slice_s, b_slice_s, sum_s;
    logic             c_out_s;
    logic [N-1:0]     diff_next_s;
    logic             last_s;
    logic             of_s;

    assign a_slice_s = a_r[int'(idx_r)*CHUNK +: CHUNK];
    assign b_slice_s = b_r[int'(idx_r)*CHUNK +: CHUNK];
    assign last_s    = (idx_r == IW'(NCH - 1));

    chunk_adder #(.W(CHUNK)) u_chunk_adder (
        .a    (a_slice_s),
        .b    (b_slice_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (c_out_s)
    );

    // Full result with the current slice merged in, used for flag generation
    always_comb begin
        diff_next_s = diff_r;
        diff_next_s[int'(idx_r)*CHUNK +: CHUNK] = sum_s;
    end

    // Signed overflow: operand signs agree in the effective add, result sign differs
    always_comb begin
        if (add_r) begin
            of_s = (a_r[N-1] == b_r[N-1]) && (diff_next_s[N-1] != a_r[N-1]);
        end else begin
            of_s = (a_r[N-1] != ~b_r[N-1]) && (diff_next_s[N-1] != a_r[N-1]);
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) state_s = CALC;
                else                        state_s = IDLE;
            end
            CALC: begin
                if (last_s) state_s = DONE;
                else        state_s = CALC;
            end
            DONE: begin
                if (out_valid_r && out_ready) state_s = IDLE;
                else                          state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand latches, slice datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= {IW{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {N{1'b0}};
            b_r         <= {N{1'b0}};
            add_r       <= 1'b0;
            diff_r      <= {N{1'b0}};
            zf_r        <= 1'b0;
            sf_r        <= 1'b0;
            of_r        <= 1'b0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b_n;
                        idx_r      <= {IW{1'b0}};
                        in_ready_r <= 1'b0;
`ifdef SUB64_SEQ_ADD_MODE_EN
                        add_r      <= op_add;
                        carry_r    <= ~op_add;
`else
                        add_r      <= 1'b0;
                        carry_r    <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    diff_r  <= diff_next_s;
                    carry_r <= c_out_s;
                    if (last_s) begin
                        idx_r       <= {IW{1'b0}};
                        zf_r        <= (diff_next_s == {N{1'b0}});
                        sf_r        <= diff_next_s[N-1];
                        of_r        <= of_s;
                        cout_r      <= c_out_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign zf        = zf_r;
    assign sf        = sf_r;
    assign of        = of_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_sub_64_seq.sv
// Directed self-checking bench for sub_64_seq: arithmetic, flags, latency, backpressure, reset abort.
module tb_sub_64_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b_n;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        zf, sf, of, cout;
`ifdef SUB64_SEQ_ADD_MODE_EN
    logic        op_add = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sub_64_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b_n       (b_n),
`ifdef SUB64_SEQ_ADD_MODE_EN
        .op_add    (op_add),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
        .cout      (cout)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present operands at a falling edge, let the next rising edge accept them, then scramble inputs.
    task automatic start_op(input logic [63:0] av, input logic [63:0] bv);
        @(negedge clk);
        check_val("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a        = av;
        b_n      = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 64'hDEAD_BEEF_CAFE_F00D;
        b_n      = 64'h0123_4567_89AB_CDEF;
    endtask

    // Count rising edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_valid(input string tag);
        int lat;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        if (!out_valid) lat = 99;
        check_val({tag, "_latency"}, 64'(lat), 64'd5);
    endtask

    task automatic check_res(input string tag, input logic [63:0] d,
                             input logic z, input logic s, input logic o, input logic c);
        check_val({tag, "_diff"}, diff, d);
        check_val({tag, "_zf"}, {63'd0, zf}, {63'd0, z});
        check_val({tag, "_sf"}, {63'd0, sf}, {63'd0, s});
        check_val({tag, "_of"}, {63'd0, of}, {63'd0, o});
        check_val({tag, "_cout"}, {63'd0, cout}, {63'd0, c});
    endtask

    // Complete the output handshake (out_ready assumed high) and confirm the return to idle.
    task automatic finish_op(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check_val({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 64'd0;
        b_n       = 64'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_res("rst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5 - 3
        start_op(64'd5, ~64'd3);
        wait_valid("t1");
        check_res("t1", 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_op("t1");

        // 3 - 5 borrows
        start_op(64'd3, ~64'd5);
        wait_valid("t2");
        check_res("t2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        finish_op("t2");

        // equal operands
        start_op(64'h1234, ~64'h1234);
        wait_valid("t3");
        check_res("t3", 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        finish_op("t3");

        // most-negative minus one overflows
        start_op(64'h8000_0000_0000_0000, ~64'd1);
        wait_valid("t4");
        check_res("t4", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        finish_op("t4");

        // carry crossing every slice boundary: 0x1_0000_0000_0000 - 1
        start_op(64'h0001_0000_0000_0000, ~64'd1);
        wait_valid("t5");
        check_res("t5", 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_op("t5");

        // backpressure: result held, new request ignored until handshake
        out_ready = 1'b0;
        start_op(64'd7, ~64'd2);
        wait_valid("t6");
        in_valid = 1'b1;
        a        = 64'd100;
        b_n      = ~64'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("t6_hold_valid", {63'd0, out_valid}, 64'd1);
            check_val("t6_hold_ready", {63'd0, in_ready}, 64'd0);
            check_val("t6_hold_diff", diff, 64'd5);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("t6_valid_drop", {63'd0, out_valid}, 64'd0);
        check_val("t6_ready_back", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid("t7");
        check_res("t7", 64'd99, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_op("t7");

        // reset during the second CALC cycle aborts the op
        start_op(64'd50, ~64'd20);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("t8_valid", {63'd0, out_valid}, 64'd0);
        check_val("t8_ready", {63'd0, in_ready}, 64'd1);
        check_res("t8", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_op(64'd10, ~64'd4);
        wait_valid("t9");
        check_res("t9", 64'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_op("t9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
